// File: rtl/nash_pkg.sv
// rtl/nash_pkg.sv - shared types and width helpers for the Nash permutation engine
// Purpose: FSM state encoding, key byte field positions, table size derivation.
// Ports: none (package).
package nash_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } nash_fsm_e;

  // Bit of a key byte carrying the transform flag; next_state sits in the low bits.
  localparam int KEY_T_BIT = 7;

  // Entries per colour table.
  function automatic int nash_entries(input int state_width);
    return 1 << state_width;
  endfunction

  // Load counter spans both colours, so it needs one bit more than the state.
  function automatic int nash_cnt_width(input int state_width);
    return state_width + 1;
  endfunction

endpackage

// File: rtl/nash_perm_table.sv
// rtl/nash_perm_table.sv - red/blue permutation table storage
// Purpose: two 2^STATE_WIDTH x (STATE_WIDTH+1) arrays of {transform, next_state}.
// Ports:
//   i_clk    clock
//   i_we     write enable
//   i_waddr  {colour, index}; colour 0 = red, 1 = blue
//   i_wdata  {transform, next_state}
//   i_raddr  shared read index
//   o_red    red entry at i_raddr (combinational)
//   o_blue   blue entry at i_raddr (combinational)
module nash_perm_table
  import nash_pkg::*;
#(
  parameter int STATE_WIDTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_we,
  input  logic [STATE_WIDTH:0]   i_waddr,
  input  logic [STATE_WIDTH:0]   i_wdata,
  input  logic [STATE_WIDTH-1:0] i_raddr,
  output logic [STATE_WIDTH:0]   o_red,
  output logic [STATE_WIDTH:0]   o_blue
);

  localparam int N = nash_entries(STATE_WIDTH);

  // No reset: contents are only trusted once a full load has completed.
  logic [STATE_WIDTH:0] r_red  [N];
  logic [STATE_WIDTH:0] r_blue [N];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      if (i_waddr[STATE_WIDTH]) begin
        r_blue[i_waddr[STATE_WIDTH-1:0]] <= i_wdata;
      end else begin
        r_red[i_waddr[STATE_WIDTH-1:0]] <= i_wdata;
      end
    end
  end

  assign o_red  = r_red[i_raddr];
  assign o_blue = r_blue[i_raddr];

endmodule

// File: rtl/nash_perm_engine.sv
// rtl/nash_perm_engine.sv - Nash autokey bit engine with runtime-loaded tables
// Purpose: loads red/blue tables from a key byte stream, then steps the cipher
//          state one bit per handshake in encrypt or decrypt mode.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   load_start                    pulse, (re)start table load
//   key_valid/key_data/key_ready  key byte stream; load_done pulses after last byte
//   tables_valid                  tables hold a complete key
//   decrypt, resync               mode select, state resync pulse
//   in_valid/in_bit/in_ready      input bit stream
//   out_valid/out_bit/out_ready   registered result bit stream
//   state_o                       current cipher state
module nash_perm_engine
  import nash_pkg::*;
#(
  parameter int STATE_WIDTH = 4,
  parameter int INIT_STATE  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_start,
  input  logic                   key_valid,
  input  logic [7:0]             key_data,
  output logic                   key_ready,
  output logic                   load_done,
  output logic                   tables_valid,
  input  logic                   decrypt,
  input  logic                   resync,
  input  logic                   in_valid,
  input  logic                   in_bit,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic                   out_bit,
  input  logic                   out_ready,
  output logic [STATE_WIDTH-1:0] state_o
);

  localparam int                     CW       = nash_cnt_width(STATE_WIDTH);
  localparam logic [CW-1:0]          LAST_CNT = '1;
  localparam logic [STATE_WIDTH-1:0] INIT     = STATE_WIDTH'(INIT_STATE);

  nash_fsm_e              r_fsm;
  nash_fsm_e              w_fsm_nxt;
  logic [CW-1:0]          r_cnt;
  logic                   r_tables_valid;
  logic                   r_load_done;
  logic                   r_out_valid;
  logic                   r_out_bit;
  logic [STATE_WIDTH-1:0] r_state;

  logic                   w_key_ready;
  logic                   w_in_ready;
  logic                   w_key_hs;
  logic                   w_last;
  logic                   w_in_hs;
  logic [STATE_WIDTH:0]   w_red;
  logic [STATE_WIDTH:0]   w_blue;
  logic                   w_t;
  logic                   w_p;
  logic [STATE_WIDTH-1:0] w_ns;
  logic                   w_unused;

  // load_start overrides any same-cycle handshake on either stream.
  assign w_key_hs = key_valid && (r_fsm == LOAD) && !load_start;
  assign w_last   = w_key_hs && (r_cnt == LAST_CNT);
  assign w_in_hs  = in_valid && w_in_ready && !load_start;

  nash_perm_table #(
    .STATE_WIDTH(STATE_WIDTH)
  ) u_table (
    .i_clk  (clk),
    .i_we   (w_key_hs),
    .i_waddr(r_cnt),
    .i_wdata({key_data[KEY_T_BIT], key_data[STATE_WIDTH-1:0]}),
    .i_raddr(r_state),
    .o_red  (w_red),
    .o_blue (w_blue)
  );

  // Transform always comes from red; the plaintext bit picks the successor colour.
  assign w_t  = w_red[STATE_WIDTH];
  assign w_p  = decrypt ? (in_bit ^ w_t) : in_bit;
  assign w_ns = w_p ? w_red[STATE_WIDTH-1:0] : w_blue[STATE_WIDTH-1:0];

  // Blue transform and the spare key bits carry no meaning for the step.
  assign w_unused = &{1'b0, key_data, w_blue[STATE_WIDTH]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm <= IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_key_ready = 1'b0;
    w_in_ready  = 1'b0;
    case (r_fsm)
      IDLE: ;
      LOAD: begin
        w_key_ready = 1'b1;
        if (w_last) w_fsm_nxt = RUN;
      end
      RUN: begin
        w_in_ready = !r_out_valid || out_ready;
      end
      default: w_fsm_nxt = IDLE;
    endcase
    if (load_start) w_fsm_nxt = LOAD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt          <= '0;
      r_tables_valid <= 1'b0;
      r_load_done    <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_bit      <= 1'b0;
      r_state        <= INIT;
    end else begin
      r_load_done <= 1'b0;
      if (load_start) begin
        r_tables_valid <= 1'b0;
        r_out_valid    <= 1'b0;
        r_cnt          <= '0;
      end else begin
        if (w_key_hs) begin
          if (w_last) begin
            r_cnt          <= '0;
            r_load_done    <= 1'b1;
            r_tables_valid <= 1'b1;
            r_state        <= INIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        // Output bit is in ^ t in both modes; only the successor choice differs.
        if (w_in_hs) begin
          r_out_bit   <= in_bit ^ w_t;
          r_out_valid <= 1'b1;
          r_state     <= w_ns;
        end else if (r_out_valid && out_ready) begin
          r_out_valid <= 1'b0;
        end
        // Placed last so resync wins the state update over a coincident step.
        if (resync && (r_fsm == RUN)) begin
          r_state <= INIT;
        end
      end
    end
  end

  assign key_ready    = w_key_ready;
  assign in_ready     = w_in_ready;
  assign load_done    = r_load_done;
  assign tables_valid = r_tables_valid;
  assign out_valid    = r_out_valid;
  assign out_bit      = r_out_bit;
  assign state_o      = r_state;

endmodule
